// File: rtl/sdk_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdk_uart_pkg
// Description : Shared types and constants for the sudoku UART frame path.
// Revision    : 1.0 - initial release
// ============================================================================
package sdk_uart_pkg;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LOAD = 2'd1,
        S_CSUM = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHAR    = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] C_SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] C_ASCII_ZERO = 8'h30;
    localparam logic [7:0] C_ASCII_ONE  = 8'h31;
    localparam logic [7:0] C_ASCII_NINE = 8'h39;
    localparam logic [7:0] C_ASCII_DOT  = 8'h2E;

endpackage : sdk_uart_pkg
`default_nettype wire

// File: rtl/ascii_cell_decode.sv
`default_nettype none
// ============================================================================
// Module      : ascii_cell_decode
// Description : Maps an ASCII byte to a sudoku cell value ('0'/'.' = blank).
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_cell_decode
    import sdk_uart_pkg::*;
(
    input  logic [7:0] ascii_byte,
    output logic       is_valid,
    output logic [3:0] value
);

    always_comb begin
        is_valid = 1'b0;
        value    = 4'd0;
        if (ascii_byte >= C_ASCII_ONE && ascii_byte <= C_ASCII_NINE) begin
            is_valid = 1'b1;
            value    = ascii_byte[3:0];
        end else if (ascii_byte == C_ASCII_ZERO || ascii_byte == C_ASCII_DOT) begin
            is_valid = 1'b1;
        end
    end

endmodule : ascii_cell_decode
`default_nettype wire

// File: rtl/puzzle_loader.sv
`default_nettype none
// ============================================================================
// Module      : puzzle_loader
// Description : Hunts for a sync byte, assembles a checksummed sudoku grid and
//               offers it to the solver over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module puzzle_loader
    import sdk_uart_pkg::*;
#(
    parameter int         NUM_CELLS      = 81,
    parameter logic [7:0] SYNC_BYTE      = C_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         CNT_W          = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_ready,
    input  logic [7:0]             uart_byte,
    output logic                   rx_hold,
    output logic [NUM_CELLS*4-1:0] puzzle,
    output logic                   puzzle_valid,
    input  logic                   puzzle_ready,
    output logic                   err_pulse,
    output logic [1:0]             err_code,
    output logic                   overrun
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_idx;
    logic [7:0]         r_csum;
    logic [TMR_W-1:0]   r_timer;

    logic               w_cell_valid;
    logic [3:0]         w_cell_value;
    logic               w_byte;
    logic               w_timeout;

    ascii_cell_decode u_decode (
        .ascii_byte (uart_byte),
        .is_valid   (w_cell_valid),
        .value      (w_cell_value)
    );

    // Bytes arriving while the host was told to pause are dropped.
    assign w_byte    = byte_ready && !rx_hold;
    // Abort on the idle cycle that would bring the timer to TIMEOUT_CYCLES-1.
    assign w_timeout = !byte_ready && (r_timer == TMR_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_idx        <= '0;
            r_csum       <= '0;
            r_timer      <= '0;
            puzzle       <= '0;
            puzzle_valid <= 1'b0;
            rx_hold      <= 1'b0;
            err_pulse    <= 1'b0;
            err_code     <= ERR_NONE;
            overrun      <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            rx_hold   <= 1'b0;
            if (byte_ready && rx_hold) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_HUNT: begin
                    if (w_byte && uart_byte == SYNC_BYTE) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                        r_csum  <= '0;
                        r_timer <= '0;
                    end
                end

                S_LOAD: begin
                    if (w_byte) begin
                        r_timer <= '0;
                        if (w_cell_valid) begin
                            puzzle[4*r_idx +: 4] <= w_cell_value;
                            r_csum               <= r_csum ^ uart_byte;
                            if (r_idx == CNT_W'(NUM_CELLS - 1)) begin
                                r_state <= S_CSUM;
                                r_idx   <= '0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_state   <= S_HUNT;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_CHAR;
                            r_idx     <= '0;
                            r_csum    <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_HUNT;
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        r_idx     <= '0;
                        r_csum    <= '0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_CSUM: begin
                    if (w_byte) begin
                        r_timer <= '0;
                        rx_hold <= 1'b1;
                        r_csum  <= '0;
                        if (uart_byte == r_csum) begin
                            r_state      <= S_HOLD;
                            puzzle_valid <= 1'b1;
                        end else begin
                            r_state   <= S_HUNT;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_CSUM;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_HUNT;
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        r_csum    <= '0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (puzzle_valid && puzzle_ready) begin
                        puzzle_valid <= 1'b0;
                        r_state      <= S_HUNT;
                    end else begin
                        rx_hold <= 1'b1;
                    end
                end

                default: r_state <= S_HUNT;
            endcase
        end
    end

endmodule : puzzle_loader
`default_nettype wire
